// File: rtl/bo_pkg.sv
// Shared definitions for the countdown/accumulate datapath and its controller.
package bo_pkg;

  localparam int BO_WIDTH     = 8;
  localparam int BO_ACC_WIDTH = 16;

  localparam int unsigned CNT_RST = 0;
  localparam int unsigned ACC_RST = 0;

  typedef struct packed {
    logic set;
    logic rac;
    logic dec;
    logic cac;
  } cmd_t;

endpackage

// File: rtl/bo_down_counter.sv
// Loadable down-counter that floors at zero instead of wrapping.
module bo_down_counter
  import bo_pkg::*;
#(
  parameter int WIDTH = BO_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             zero
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= WIDTH'(CNT_RST);
    end else if (load) begin
      cnt <= d;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign q    = cnt;
  assign zero = (cnt == '0);

endmodule

// File: rtl/bo_countdown.sv
// Countdown/accumulate datapath: loop counter CNT plus accumulator ACC.
// Define BO_SAT_EN to saturate ACC on overflow and raise the sticky ovf flag.
module bo_countdown
  import bo_pkg::*;
#(
  parameter int WIDTH     = BO_WIDTH,
  parameter int ACC_WIDTH = BO_ACC_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     n_in,
  input  logic                 set,
  input  logic                 rac,
  input  logic                 dec,
  input  logic                 cac,
  output logic                 zero,
  output logic [WIDTH-1:0]     cnt_out,
  output logic [ACC_WIDTH-1:0] acc_out,
  output logic                 ovf
);

  cmd_t                 cmd;
  logic [WIDTH-1:0]     cnt;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH:0]   sum;

  assign cmd = '{set: set, rac: rac, dec: dec, cac: cac};

  bo_down_counter #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (cmd.set),
    .dec  (cmd.dec),
    .d    (n_in),
    .q    (cnt),
    .zero (zero)
  );

  // cnt is the pre-update register value, so cac always adds the old CNT
  assign sum = {1'b0, acc} + (ACC_WIDTH + 1)'(cnt);

`ifdef BO_SAT_EN
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= ACC_WIDTH'(ACC_RST);
      ovf_q <= 1'b0;
    end else if (cmd.rac) begin
      acc   <= '0;
      ovf_q <= 1'b0;
    end else if (cmd.cac) begin
      if (sum[ACC_WIDTH]) begin
        acc   <= '1;
        ovf_q <= 1'b1;
      end else begin
        acc <= sum[ACC_WIDTH-1:0];
      end
    end
  end

  assign ovf = ovf_q;
`else
  logic unused_carry;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= ACC_WIDTH'(ACC_RST);
    end else if (cmd.rac) begin
      acc <= '0;
    end else if (cmd.cac) begin
      acc <= sum[ACC_WIDTH-1:0];
    end
  end

  assign unused_carry = sum[ACC_WIDTH];
  assign ovf          = 1'b0;
`endif

  assign cnt_out = cnt;
  assign acc_out = acc;

endmodule

// File: doc/bo_countdown.md
# bo_countdown

Datapath ("bloco operativo") paired with the countdown/accumulate control FSM. It executes the controller's one-hot command strobes `set`, `rac`, `dec` and `cac` on a loop counter CNT and an accumulator ACC, and returns the `zero` status the controller branches on. For a normal run (load N, then alternate accumulate and decrement until zero) ACC ends at N+(N-1)+…+1.

## Interface
- `WIDTH`, default 8: width of `n_in` and CNT.
- `ACC_WIDTH`, default 16: width of ACC; must be ≥ WIDTH.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: reset rst, synchronous, active-high; clock clk.
- `n_in`  in  WIDTH: start value, loaded into CNT on `set`.
- `set`  in  1: CNT ← `n_in`.
- `rac`  in  1: ACC ← 0; also clears `ovf`.
- `dec`  in  1: CNT ← CNT−1.
- `cac`  in  1: ACC ← ACC + zero-extended CNT.
- `zero`  out  1: CNT == 0, combinational from the CNT register.
- `cnt_out`  out  WIDTH: current CNT.
- `acc_out`  out  ACC_WIDTH: current ACC.
- `ovf`  out  1: sticky accumulator-overflow flag. Tied 0 unless `BO_SAT_EN` is defined.

## Operation
- **Registers:** CNT and ACC only. No FSM in this block; sequencing belongs to the controller.
- **CNT update priority:** `set` > `dec` > hold. If `set` and `dec` are both high, CNT = `n_in` (no decrement).
- **CNT at zero:** `dec` with CNT == 0 holds CNT at 0. CNT never wraps to all-ones.
- **ACC update priority:** `rac` > `cac` > hold. If `rac` and `cac` are both high, ACC = 0.
- **`cac` with `dec` in the same cycle:** `cac` adds the pre-decrement CNT value.
- **`set` with `cac` in the same cycle:** `cac` adds the old CNT, not `n_in`.
- **Independent registers:** commands on different registers act in parallel. `set`+`rac` together (controller idle state) loads CNT and clears ACC in one cycle.
- **Adder width:** the adder is ACC_WIDTH+1 bits. The carry-out is the overflow indicator.
- **Without saturation:** overflow discards the carry, so ACC wraps modulo 2^ACC_WIDTH.

## Timing
- **Reset:** `rst` high at a rising edge sets CNT=0, ACC=0, ovf=0. Consequently `zero`=1, `cnt_out`=0, `acc_out`=0 after reset.
- **Reset priority:** reset overrides every command in the same cycle. Reset mid-run abandons the operation with no partial state kept.
- **Command latency:** one cycle. A command sampled at edge k is visible on the outputs after edge k.
- **`zero` timing:** `zero` tracks CNT with no extra delay. The controller sees `zero` in the cycle after the `dec` that produced it, and branches on it at the following edge.
- **No handshake:** commands are level strobes sampled every edge. Holding `dec` for m cycles decrements m times, saturating at 0.

## Configuration
- **`BO_SAT_EN` defined:**
  - On carry-out, ACC ← 2^ACC_WIDTH−1 and `ovf` ← 1.
  - `ovf` stays 1 until `rac` or `rst`.
  - While saturated, further `cac` keeps ACC at all-ones.
- **`BO_SAT_EN` undefined:** ACC wraps, and `ovf` is constant 0.

## Structure
- **Package `bo_pkg`:**
  - default `WIDTH`/`ACC_WIDTH` localparams
  - `cmd_t` packed struct {set, rac, dec, cac}, shared with the controller and the testbench
  - the reset constants for CNT and ACC
- **Sub-module `bo_down_counter`:** parameterised WIDTH register with load/decrement/hold and the zero-floor rule. It outputs the count and `zero`.
- **Top level:** `bo_countdown` instantiates the counter and implements the ACC register, adder and saturation logic.

## Test plan
All cases use WIDTH=8 unless stated.
- **Reset:** reset, then idle → `zero`=1, `cnt_out`=0, `acc_out`=0, `ovf`=0.
- **Nominal run:** `n_in`=5 with `set`+`rac`, then alternate `cac`,`dec` until `zero` → `zero` rises after the 5th `dec`, `acc_out`=15.
- **Simultaneous commands:**
  - CNT=3, `set`(`n_in`=9)+`dec` → CNT=9.
  - then `cac`+`dec` → ACC += 9, CNT=8.
  - then `rac`+`cac` → ACC=0.
- **Decrement at zero:** CNT=0, `dec` held 4 cycles → CNT stays 0, `zero` stays 1.
- **Overflow:** ACC_WIDTH=8, `n_in`=200, `cac` twice. Without `BO_SAT_EN` → `acc_out`=144, `ovf`=0. With it → `acc_out`=255, `ovf`=1; then `rac` → ACC=0, `ovf`=0.
- **Reset mid-run:** `rst` during a run with CNT=4, ACC=7 → all outputs return to their reset values the next cycle, and a following `set` with `n_in`=2 behaves normally.
